// File: rtl/instr_decode.sv
// instr_decode
// MIPS-I integer decode stage. Holds the IF/ID pipeline register and the
// 32x32 general-purpose register file, decodes the fetched instruction into
// execute-stage controls, and registers operands, immediates and jump target.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   if_valid/if_instr/if_pc instruction from fetch
//   stall, flush            hold / squash the ID register
//   wb_en/wb_addr/wb_data   register-file write port (writeback)
//   id_valid, id_pc         live flag and PC of the decoded instruction
//   id_rs_data/id_rt_data   operand values (writeback-bypassed)
//   id_rs/id_rt/id_dest     register numbers for forwarding / writeback
//   id_imm, id_shamt        extended immediate and shift amount
//   id_jtarget              pseudo-direct jump target
//   id_alu_op, id_alu_src   ALU operation and B-operand select
//   id_reg_write ... id_illegal  single-bit execute/memory controls
module instr_decode (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    input  logic        stall,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_rs_data,
    output logic [31:0] id_rt_data,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_dest,
    output logic [31:0] id_imm,
    output logic [4:0]  id_shamt,
    output logic [31:0] id_jtarget,
    output logic [3:0]  id_alu_op,
    output logic        id_alu_src,
    output logic        id_reg_write,
    output logic        id_mem_read,
    output logic        id_mem_write,
    output logic        id_mem_to_reg,
    output logic        id_beq,
    output logic        id_bne,
    output logic        id_jump,
    output logic        id_jump_reg,
    output logic        id_link,
    output logic        id_illegal
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    logic [5:0]  f_opcode;
    logic [5:0]  f_funct;
    logic [4:0]  f_rs;
    logic [4:0]  f_rt;
    logic [4:0]  f_rd;

    assign f_opcode = if_instr[31:26];
    assign f_funct  = if_instr[5:0];
    assign f_rs     = if_instr[25:21];
    assign f_rt     = if_instr[20:16];
    assign f_rd     = if_instr[15:11];

    logic [31:0] regs [32];
    logic [31:0] rs_val;
    logic [31:0] rt_val;

    logic [3:0]  dec_alu_op;
    logic        dec_alu_src;
    logic        dec_reg_write;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic        dec_mem_to_reg;
    logic        dec_beq;
    logic        dec_bne;
    logic        dec_jump;
    logic        dec_jump_reg;
    logic        dec_link;
    logic        dec_illegal;
    logic        dec_zero_ext;
    logic        dec_lui;
    logic [4:0]  dec_dest;
    logic [31:0] dec_imm;
    logic [31:0] dec_jtarget;

    // Register file. Entry 0 is never written, so it stays 0 after reset;
    // the read path also forces it to 0 independently of storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && (wb_addr != 5'd0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Operand reads with write-through: a writeback landing on the same edge
    // as the load must be seen, since the array itself only updates at the edge.
    always_comb begin
        rs_val = regs[f_rs];
        if (f_rs == 5'd0) begin
            rs_val = '0;
        end else if (wb_en && (wb_addr == f_rs)) begin
            rs_val = wb_data;
        end
        rt_val = regs[f_rt];
        if (f_rt == 5'd0) begin
            rt_val = '0;
        end else if (wb_en && (wb_addr == f_rt)) begin
            rt_val = wb_data;
        end
    end

    // Instruction decode. Every path starts from "do nothing, not illegal";
    // unsupported encodings land in a default that only raises dec_illegal.
    always_comb begin
        dec_alu_op     = ALU_ADD;
        dec_alu_src    = 1'b0;
        dec_reg_write  = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_beq        = 1'b0;
        dec_bne        = 1'b0;
        dec_jump       = 1'b0;
        dec_jump_reg   = 1'b0;
        dec_link       = 1'b0;
        dec_illegal    = 1'b0;
        dec_zero_ext   = 1'b0;
        dec_lui        = 1'b0;
        dec_dest       = f_rt;

        case (f_opcode)
            6'h00: begin
                dec_dest      = f_rd;
                dec_reg_write = 1'b1;
                case (f_funct)
                    6'h20, 6'h21: dec_alu_op = ALU_ADD;
                    6'h22, 6'h23: dec_alu_op = ALU_SUB;
                    6'h24:        dec_alu_op = ALU_AND;
                    6'h25:        dec_alu_op = ALU_OR;
                    6'h26:        dec_alu_op = ALU_XOR;
                    6'h27:        dec_alu_op = ALU_NOR;
                    6'h2A:        dec_alu_op = ALU_SLT;
                    6'h2B:        dec_alu_op = ALU_SLTU;
                    6'h00:        dec_alu_op = ALU_SLL;
                    6'h02:        dec_alu_op = ALU_SRL;
                    6'h03:        dec_alu_op = ALU_SRA;
                    6'h08: begin
                        dec_reg_write = 1'b0;
                        dec_jump_reg  = 1'b1;
                    end
                    default: begin
                        dec_reg_write = 1'b0;
                        dec_illegal   = 1'b1;
                    end
                endcase
            end
            6'h08, 6'h09: begin
                dec_alu_op    = ALU_ADD;
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
            end
            6'h0A: begin
                dec_alu_op    = ALU_SLT;
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
            end
            6'h0B: begin
                dec_alu_op    = ALU_SLTU;
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
            end
            6'h0C: begin
                dec_alu_op    = ALU_AND;
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
                dec_zero_ext  = 1'b1;
            end
            6'h0D: begin
                dec_alu_op    = ALU_OR;
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
                dec_zero_ext  = 1'b1;
            end
            6'h0E: begin
                dec_alu_op    = ALU_XOR;
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
                dec_zero_ext  = 1'b1;
            end
            6'h0F: begin
                dec_alu_op    = ALU_LUI;
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
                dec_lui       = 1'b1;
            end
            6'h23: begin
                dec_alu_src    = 1'b1;
                dec_reg_write  = 1'b1;
                dec_mem_read   = 1'b1;
                dec_mem_to_reg = 1'b1;
            end
            6'h2B: begin
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
            end
            6'h04: begin
                dec_alu_op = ALU_SUB;
                dec_beq    = 1'b1;
            end
            6'h05: begin
                dec_alu_op = ALU_SUB;
                dec_bne    = 1'b1;
            end
            6'h02: begin
                dec_jump = 1'b1;
            end
            6'h03: begin
                dec_jump      = 1'b1;
                dec_link      = 1'b1;
                dec_reg_write = 1'b1;
                dec_dest      = 5'd31;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Immediate extension and jump target. The upper jump-target nibble comes
    // from PC+4 so a jump in the last slot of a 256 MB region targets the next one.
    always_comb begin
        if (dec_lui) begin
            dec_imm = {if_instr[15:0], 16'h0000};
        end else if (dec_zero_ext) begin
            dec_imm = {16'h0000, if_instr[15:0]};
        end else begin
            dec_imm = {{16{if_instr[15]}}, if_instr[15:0]};
        end
        dec_jtarget = ((if_pc + 32'd4) & 32'hF000_0000) |
                      {4'b0000, if_instr[25:0], 2'b00};
    end

    // IF/ID register. Priority is reset, flush, stall, load. A flush only
    // clears the live flag and controls; data fields keep their old contents.
    // During a stall the held operands still track writebacks to their
    // source registers so the stalled instruction never sees stale data.
    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid      <= 1'b0;
            id_pc         <= '0;
            id_rs_data    <= '0;
            id_rt_data    <= '0;
            id_rs         <= '0;
            id_rt         <= '0;
            id_dest       <= '0;
            id_imm        <= '0;
            id_shamt      <= '0;
            id_jtarget    <= '0;
            id_alu_op     <= '0;
            id_alu_src    <= 1'b0;
            id_reg_write  <= 1'b0;
            id_mem_read   <= 1'b0;
            id_mem_write  <= 1'b0;
            id_mem_to_reg <= 1'b0;
            id_beq        <= 1'b0;
            id_bne        <= 1'b0;
            id_jump       <= 1'b0;
            id_jump_reg   <= 1'b0;
            id_link       <= 1'b0;
            id_illegal    <= 1'b0;
        end else if (flush) begin
            id_valid      <= 1'b0;
            id_alu_op     <= '0;
            id_alu_src    <= 1'b0;
            id_reg_write  <= 1'b0;
            id_mem_read   <= 1'b0;
            id_mem_write  <= 1'b0;
            id_mem_to_reg <= 1'b0;
            id_beq        <= 1'b0;
            id_bne        <= 1'b0;
            id_jump       <= 1'b0;
            id_jump_reg   <= 1'b0;
            id_link       <= 1'b0;
            id_illegal    <= 1'b0;
        end else if (stall) begin
            if (wb_en && (wb_addr != 5'd0) && (wb_addr == id_rs)) begin
                id_rs_data <= wb_data;
            end
            if (wb_en && (wb_addr != 5'd0) && (wb_addr == id_rt)) begin
                id_rt_data <= wb_data;
            end
        end else begin
            id_valid      <= if_valid;
            id_pc         <= if_pc;
            id_rs_data    <= rs_val;
            id_rt_data    <= rt_val;
            id_rs         <= f_rs;
            id_rt         <= f_rt;
            id_dest       <= dec_dest;
            id_imm        <= dec_imm;
            id_shamt      <= if_instr[10:6];
            id_jtarget    <= dec_jtarget;
            id_alu_op     <= if_valid ? dec_alu_op : 4'd0;
            id_alu_src    <= if_valid & dec_alu_src;
            id_reg_write  <= if_valid & dec_reg_write;
            id_mem_read   <= if_valid & dec_mem_read;
            id_mem_write  <= if_valid & dec_mem_write;
            id_mem_to_reg <= if_valid & dec_mem_to_reg;
            id_beq        <= if_valid & dec_beq;
            id_bne        <= if_valid & dec_bne;
            id_jump       <= if_valid & dec_jump;
            id_jump_reg   <= if_valid & dec_jump_reg;
            id_link       <= if_valid & dec_link;
            id_illegal    <= if_valid & dec_illegal;
        end
    end

endmodule

// File: tb/tb_instr_decode.sv
// tb_instr_decode
// Self-checking bench for instr_decode: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model built from the instruction-set tables.
module tb_instr_decode;

    logic        clk;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        stall;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_dest;
    logic [31:0] id_imm;
    logic [4:0]  id_shamt;
    logic [31:0] id_jtarget;
    logic [3:0]  id_alu_op;
    logic        id_alu_src;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        id_mem_to_reg;
    logic        id_beq;
    logic        id_bne;
    logic        id_jump;
    logic        id_jump_reg;
    logic        id_link;
    logic        id_illegal;

    instr_decode dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .stall(stall), .flush(flush), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest), .id_imm(id_imm),
        .id_shamt(id_shamt), .id_jtarget(id_jtarget), .id_alu_op(id_alu_op),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_beq(id_beq), .id_bne(id_bne),
        .id_jump(id_jump), .id_jump_reg(id_jump_reg), .id_link(id_link),
        .id_illegal(id_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected ID-register contents; the *_known flags mark fields the
    // instruction set actually defines for the current contents.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [31:0] jtarget;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        beq;
        logic        bne;
        logic        jump;
        logic        jump_reg;
        logic        link;
        logic        illegal;
        logic        data_known;
        logic        alu_known;
        logic        mtr_known;
    } id_model_t;

    id_model_t   m;
    logic [31:0] mregs [32];
    int          r_alu [int];
    int          i_alu [int];
    logic [5:0]  r_functs [16];
    logic [5:0]  i_ops [16];
    int          checks = 0;
    int          errors = 0;

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] readModel(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_en && wb_addr == a) return wb_data;
        return mregs[a];
    endfunction

    // Table-driven reference decode of one instruction word.
    function automatic id_model_t refDecode(input logic [31:0] ins, input logic [31:0] pc);
        id_model_t e;
        int op;
        int fn;
        logic [31:0] pc4;
        e = '0;
        op = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        pc4 = pc + 32'd4;
        e.valid = 1'b1;
        e.pc = pc;
        e.rs = ins[25:21];
        e.rt = ins[20:16];
        e.shamt = ins[10:6];
        e.jtarget = {pc4[31:28], ins[25:0], 2'b00};
        e.dest = ins[20:16];
        e.data_known = 1'b1;
        if (op == 'h0C || op == 'h0D || op == 'h0E) e.imm = {16'h0, ins[15:0]};
        else if (op == 'h0F) e.imm = {ins[15:0], 16'h0};
        else e.imm = {{16{ins[15]}}, ins[15:0]};
        if (op == 0) begin
            e.dest = ins[15:11];
            if (r_alu.exists(fn)) begin
                e.reg_write = 1'b1;
                e.alu_op = 4'(r_alu[fn]);
                e.alu_known = 1'b1;
            end else if (fn == 'h08) e.jump_reg = 1'b1;
            else e.illegal = 1'b1;
        end else if (i_alu.exists(op)) begin
            e.reg_write = 1'b1;
            e.alu_op = 4'(i_alu[op]);
            e.alu_src = 1'b1;
            e.alu_known = 1'b1;
        end else begin
            case (op)
                'h23: begin e.reg_write = 1'b1; e.mem_read = 1'b1; e.mem_to_reg = 1'b1; end
                'h2B: e.mem_write = 1'b1;
                'h04: begin e.beq = 1'b1; e.alu_op = 4'd1; e.alu_known = 1'b1; end
                'h05: begin e.bne = 1'b1; e.alu_op = 4'd1; e.alu_known = 1'b1; end
                'h02: e.jump = 1'b1;
                'h03: begin e.jump = 1'b1; e.link = 1'b1; e.reg_write = 1'b1; e.dest = 5'd31; end
                default: e.illegal = 1'b1;
            endcase
        end
        e.mtr_known = !e.illegal;
        return e;
    endfunction

    // Advance the model by one clock edge using the inputs present at it.
    task automatic modelStep();
        logic [31:0] rs_read;
        logic [31:0] rt_read;
        id_model_t   e;
        rs_read = readModel(if_instr[25:21]);
        rt_read = readModel(if_instr[20:16]);
        if (reset) begin
            m = '0;
            m.data_known = 1'b1;
            m.alu_known = 1'b1;
            m.mtr_known = 1'b1;
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
            return;
        end
        if (flush) begin
            m = '0;
            m.mtr_known = 1'b1;
        end else if (stall) begin
            if (m.data_known && wb_en && wb_addr != 5'd0 && wb_addr == m.rs) m.rs_data = wb_data;
            if (m.data_known && wb_en && wb_addr != 5'd0 && wb_addr == m.rt) m.rt_data = wb_data;
        end else begin
            e = refDecode(if_instr, if_pc);
            e.rs_data = rs_read;
            e.rt_data = rt_read;
            if (!if_valid) begin
                e.valid = 1'b0;
                e.reg_write = 1'b0; e.mem_read = 1'b0; e.mem_write = 1'b0;
                e.mem_to_reg = 1'b0; e.beq = 1'b0; e.bne = 1'b0; e.jump = 1'b0;
                e.jump_reg = 1'b0; e.link = 1'b0; e.illegal = 1'b0;
                e.alu_known = 1'b0;
                e.mtr_known = 1'b1;
            end
            m = e;
        end
        if (wb_en && wb_addr != 5'd0) mregs[wb_addr] = wb_data;
    endtask

    task automatic checkOutput();
        checkField("valid", {31'd0, id_valid}, {31'd0, m.valid});
        checkField("reg_write", {31'd0, id_reg_write}, {31'd0, m.reg_write});
        checkField("mem_read", {31'd0, id_mem_read}, {31'd0, m.mem_read});
        checkField("mem_write", {31'd0, id_mem_write}, {31'd0, m.mem_write});
        checkField("beq", {31'd0, id_beq}, {31'd0, m.beq});
        checkField("bne", {31'd0, id_bne}, {31'd0, m.bne});
        checkField("jump", {31'd0, id_jump}, {31'd0, m.jump});
        checkField("jump_reg", {31'd0, id_jump_reg}, {31'd0, m.jump_reg});
        checkField("link", {31'd0, id_link}, {31'd0, m.link});
        checkField("illegal", {31'd0, id_illegal}, {31'd0, m.illegal});
        if (m.mtr_known) checkField("mem_to_reg", {31'd0, id_mem_to_reg}, {31'd0, m.mem_to_reg});
        if (m.alu_known) begin
            checkField("alu_op", {28'd0, id_alu_op}, {28'd0, m.alu_op});
            checkField("alu_src", {31'd0, id_alu_src}, {31'd0, m.alu_src});
        end
        if (m.data_known) begin
            checkField("pc", id_pc, m.pc);
            checkField("rs_data", id_rs_data, m.rs_data);
            checkField("rt_data", id_rt_data, m.rt_data);
            checkField("rs", {27'd0, id_rs}, {27'd0, m.rs});
            checkField("rt", {27'd0, id_rt}, {27'd0, m.rt});
            checkField("dest", {27'd0, id_dest}, {27'd0, m.dest});
            checkField("imm", id_imm, m.imm);
            checkField("shamt", {27'd0, id_shamt}, {27'd0, m.shamt});
            checkField("jtarget", id_jtarget, m.jtarget);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [31:0] ins,
                                 input logic [31:0] pc, input logic st, input logic fl,
                                 input logic we, input logic [4:0] wa, input logic [31:0] wd);
        @(negedge clk);
        reset = r; if_valid = v; if_instr = ins; if_pc = pc;
        stall = st; flush = fl; wb_en = we; wb_addr = wa; wb_data = wd;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    function automatic logic [31:0] genInstr();
        int k;
        logic [3:0] idx;
        logic [4:0] a;
        logic [4:0] b;
        logic [4:0] d;
        k = int'($urandom_range(0, 99));
        idx = 4'($urandom_range(0, 15));
        a = 5'($urandom_range(0, 7));
        b = 5'($urandom_range(0, 7));
        d = 5'($urandom_range(0, 7));
        if (k < 40) return {6'h00, a, b, d, 5'($urandom_range(0, 31)), r_functs[idx]};
        if (k < 85) return {i_ops[idx], a, b, 16'($urandom())};
        return $urandom();
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        r_alu[32'h20] = 0; r_alu[32'h21] = 0; r_alu[32'h22] = 1; r_alu[32'h23] = 1;
        r_alu[32'h24] = 2; r_alu[32'h25] = 3; r_alu[32'h26] = 4; r_alu[32'h27] = 5;
        r_alu[32'h2A] = 6; r_alu[32'h2B] = 7; r_alu[32'h00] = 8; r_alu[32'h02] = 9;
        r_alu[32'h03] = 10;
        i_alu[32'h08] = 0; i_alu[32'h09] = 0; i_alu[32'h0A] = 6; i_alu[32'h0B] = 7;
        i_alu[32'h0C] = 2; i_alu[32'h0D] = 3; i_alu[32'h0E] = 4; i_alu[32'h0F] = 11;
        r_functs = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                     6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08, 6'h01, 6'h3F};
        i_ops = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                  6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F, 6'h10};
        m = '0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        reset = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
        stall = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;

        // Reset, then add $3,$1,$2
        applyStimulus(1, 0, 32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0);
        checkField("lit_reset_valid", {31'd0, id_valid}, 32'd0);
        checkField("lit_reset_imm", id_imm, 32'd0);
        applyStimulus(0, 1, 32'h00221820, 32'h10, 0, 0, 0, 5'd0, 32'h0);
        checkField("lit_add_valid", {31'd0, id_valid}, 32'd1);
        checkField("lit_add_alu", {28'd0, id_alu_op}, 32'd0);
        checkField("lit_add_dest", {27'd0, id_dest}, 32'd3);
        checkField("lit_add_rw", {31'd0, id_reg_write}, 32'd1);
        checkField("lit_add_pc", id_pc, 32'h10);
        checkField("lit_add_rs", id_rs_data, 32'd0);

        // Same-edge bypass into addi $4,$1,-1
        applyStimulus(0, 1, 32'h2024FFFF, 32'h14, 0, 0, 1, 5'd1, 32'h55);
        checkField("lit_byp_rs", id_rs_data, 32'h55);
        checkField("lit_byp_imm", id_imm, 32'hFFFFFFFF);
        checkField("lit_byp_src", {31'd0, id_alu_src}, 32'd1);

        // Writes to register 0 must never be visible
        applyStimulus(0, 0, 32'h0, 32'h18, 0, 0, 1, 5'd0, 32'hDEAD);
        applyStimulus(0, 1, 32'h00002825, 32'h1C, 0, 0, 1, 5'd0, 32'hDEAD);
        checkField("lit_zero_rs", id_rs_data, 32'd0);
        checkField("lit_zero_rt", id_rt_data, 32'd0);

        // sw $2,8($1) held for three stall cycles with a writeback to $2
        applyStimulus(0, 1, 32'hAC220008, 32'h20, 0, 0, 0, 5'd0, 32'h0);
        applyStimulus(0, 1, 32'hFFFFFFFF, 32'h24, 1, 0, 1, 5'd2, 32'h77);
        applyStimulus(0, 1, 32'h00221820, 32'h28, 1, 0, 0, 5'd0, 32'h0);
        applyStimulus(0, 1, 32'h3C011234, 32'h2C, 1, 0, 0, 5'd0, 32'h0);
        checkField("lit_stall_rt", id_rt_data, 32'h77);
        checkField("lit_stall_rs", id_rs_data, 32'h55);
        checkField("lit_stall_mw", {31'd0, id_mem_write}, 32'd1);
        checkField("lit_stall_pc", id_pc, 32'h20);
        checkField("lit_stall_imm", id_imm, 32'h8);

        // lw then flush together with stall
        applyStimulus(0, 1, 32'h8C230004, 32'h30, 0, 0, 0, 5'd0, 32'h0);
        checkField("lit_lw_mr", {31'd0, id_mem_read}, 32'd1);
        applyStimulus(0, 1, 32'h00221820, 32'h34, 1, 1, 0, 5'd0, 32'h0);
        checkField("lit_flush_valid", {31'd0, id_valid}, 32'd0);
        checkField("lit_flush_mr", {31'd0, id_mem_read}, 32'd0);
        checkField("lit_flush_rw", {31'd0, id_reg_write}, 32'd0);

        // jal, lui, illegal, invalid load, zero-extended ori
        applyStimulus(0, 1, 32'h0C000040, 32'h00400000, 0, 0, 0, 5'd0, 32'h0);
        checkField("lit_jal_tgt", id_jtarget, 32'h00000100);
        checkField("lit_jal_dest", {27'd0, id_dest}, 32'd31);
        checkField("lit_jal_link", {31'd0, id_link}, 32'd1);
        applyStimulus(0, 1, 32'h3C011234, 32'h00400004, 0, 0, 0, 5'd0, 32'h0);
        checkField("lit_lui_imm", id_imm, 32'h12340000);
        checkField("lit_lui_alu", {28'd0, id_alu_op}, 32'd11);
        applyStimulus(0, 1, 32'hFC000000, 32'h00400008, 0, 0, 0, 5'd0, 32'h0);
        checkField("lit_ill_flag", {31'd0, id_illegal}, 32'd1);
        checkField("lit_ill_rw", {31'd0, id_reg_write}, 32'd0);
        checkField("lit_ill_valid", {31'd0, id_valid}, 32'd1);
        applyStimulus(0, 0, 32'h00221820, 32'h0040000C, 0, 0, 0, 5'd0, 32'h0);
        checkField("lit_inv_rw", {31'd0, id_reg_write}, 32'd0);
        applyStimulus(0, 1, 32'h3402F00F, 32'h00400010, 0, 0, 0, 5'd0, 32'h0);
        checkField("lit_ori_imm", id_imm, 32'h0000F00F);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            applyStimulus(($urandom_range(0, 99) < 1),
                          ($urandom_range(0, 99) < 85),
                          genInstr(),
                          $urandom() & 32'hFFFF_FFFC,
                          ($urandom_range(0, 99) < 20),
                          ($urandom_range(0, 99) < 8),
                          ($urandom_range(0, 99) < 60),
                          5'($urandom_range(0, 7)),
                          $urandom());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_decode.md
# instr_decode

Decode stage that directly consumes the 32-bit instruction word and its PC from instruction fetch. It holds the IF/ID pipeline register and the 32×32 general-purpose register file, and decodes MIPS-I integer instructions into control bits. Its registered operands and controls drive the execute stage. It supports stall (hold), flush (squash) and same-edge writeback bypass.

## Interface
- No parameters. Data width is fixed at 32; the register file is fixed at 32 entries.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `if_valid`  in  1  `if_instr`/`if_pc` hold a real instruction.
- `if_instr`  in  32  instruction word from fetch.
- `if_pc`  in  32  byte address of `if_instr`.
- `stall`  in  1  hold the ID register this cycle.
- `flush`  in  1  squash the ID register this cycle.
- `wb_en`  in  1  register-file write enable.
- `wb_addr`  in  5  write address.
- `wb_data`  in  32  write data.
- `id_valid`  out  1  ID outputs carry a live instruction.
- `id_pc`  out  32  PC of the decoded instruction.
- `id_rs_data`, `id_rt_data`  out  32  operand values.
- `id_rs`, `id_rt`  out  5  source register numbers (for forwarding).
- `id_dest`  out  5  destination: rd for R-type, rt for I-type, 31 for jal.
- `id_imm`  out  32  extended immediate.
- `id_shamt`  out  5  `instr[10:6]`.
- `id_jtarget`  out  32  `{pc_plus4[31:28], instr[25:0], 2'b00}`.
- `id_alu_op`  out  4  encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI.
- `id_alu_src`  out  1  0 selects rt, 1 selects imm.
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg`  out  1 each.
- `id_beq`, `id_bne`, `id_jump`, `id_jump_reg`, `id_link`  out  1 each.
- `id_illegal`  out  1  unsupported encoding.

## Operation
- Supported R-type, opcode 0, by funct:
  - add 20, addu 21 → ADD; sub 22, subu 23 → SUB.
  - and 24, or 25, xor 26, nor 27 → the matching logic op.
  - slt 2A, sltu 2B → SLT / SLTU.
  - sll 00, srl 02, sra 03 → the matching shift.
  - jr 08 → `id_jump_reg`=1, `reg_write`=0.
- Supported I-type and J-type, by opcode:
  - addi 08, addiu 09 → ADD; slti 0A → SLT; sltiu 0B → SLTU.
  - andi 0C, ori 0D, xori 0E → the matching logic op.
  - lui 0F → LUI.
  - lw 23 → `mem_read`, `mem_to_reg`; sw 2B → `mem_write`.
  - beq 04, bne 05 → SUB with `alu_src`=0; j 02; jal 03 → `jump`, `link`, `reg_write`, dest 31.
- Immediate extension:
  - andi, ori and xori zero-extend.
  - lui produces `{imm16, 16'h0}`.
  - Every other instruction sign-extends.
- Illegal instructions:
  - Any other opcode/funct sets `id_illegal`=1.
  - All of `reg_write`, `mem_read`, `mem_write`, `beq`, `bne`, `jump`, `jump_reg` and `link` are forced to 0.
  - `id_valid` still follows `if_valid`.
- Register file:
  - Register 0 always reads 0; writes to it are ignored.
  - On reset, all 32 entries clear to 0.
- Update priority each edge: `reset` > `flush` > `stall` > load.
  - **Load:** capture `if_*`, the decode result, and the register-file reads addressed by `if_instr[25:21]` and `[20:16]`. `id_valid` ← `if_valid`.
  - **Flush:** `id_valid`=0 and all control bits (including `id_illegal`) = 0. Data fields are don't-care.
  - **Stall:** every output holds, except the operand refresh below.
  - When `if_valid`=0 on a load, all control bits load as 0.

## Timing
- Latency is 1 cycle: an instruction sampled at edge N appears on the `id_*` outputs after edge N.
- Reset value of every output is 0.
- Write-through bypass:
  - If `wb_en` and `wb_addr`≠0 match a source address at the loading edge, the operand captures `wb_data`, not the stale register-file value.
  - The register-file write happens at the same edge.
- Operand refresh during stall: if `wb_en` writes `id_rs` (or `id_rt`) with a nonzero address, `id_rs_data` (or `id_rt_data`) updates to `wb_data` at that edge.
- `flush` and `stall` asserted together: flush wins.
- Reset mid-operation clears the ID register and the register file in the same edge.
- Register-file writes occur regardless of stall or flush.

## Test plan
- **Reset then add.**
  - Stimulus: assert `reset` 1 cycle, then load `add $3,$1,$2` (0x00221820) with `if_pc`=0x10.
  - Response: after 1 edge, `id_valid`=1, `id_alu_op`=0, `id_dest`=3, `id_reg_write`=1, `id_pc`=0x10, operands 0.
- **Bypass.**
  - Stimulus: `wb_en`=1, `wb_addr`=1, `wb_data`=0x55 on the same edge that loads `addi $4,$1,-1` (0x2024FFFF).
  - Response: `id_rs_data`=0x55, `id_imm`=0xFFFFFFFF, `id_alu_src`=1.
- **Zero register.**
  - Stimulus: write 0xDEAD to reg 0, then decode `or $5,$0,$0`.
  - Response: both operands = 0.
- **Stall with refresh.**
  - Stimulus: load `sw $2,8($1)`, then hold `stall`=1 for 3 cycles while writing 0x77 to reg 2 and changing `if_instr`.
  - Response: outputs are unchanged except `id_rt_data`=0x77; `id_mem_write` stays 1.
- **Flush beats stall.**
  - Stimulus: with `lw` loaded, assert `flush`=1 and `stall`=1.
  - Response: `id_valid`=0, `id_mem_read`=0, `id_reg_write`=0.
- **Jal, lui, illegal.**
  - Stimulus: `jal` 0x0C000040 at pc 0x00400000.
  - Response: `id_jtarget`=0x00000100, `id_dest`=31, `id_link`=1.
  - Stimulus: `lui` 0x3C011234.
  - Response: `id_imm`=0x12340000, `id_alu_op`=11.
  - Stimulus: opcode 0x3F.
  - Response: `id_illegal`=1, all write/branch controls 0.
